// File: rtl/hazard_unit_param.sv
// Hazard and bypass controller for the 5-stage pipeline.
// Keeps registered shadows of the E, M and W destination records and
// derives the decode stall, the execute forwarding selects, the M-stage
// store-data bypass, the memory-wait freeze and a lost-cycle counter.
//
// Memory-wait FSM
//   state   | meaning
//   MW_RUN  | pipeline advances every edge; ld_cnt held at 0
//   MW_WAIT | load sits in M; all records frozen; ld_cnt counts wait cycles
module hazard_unit_param #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_d_valid,
    input  logic              w_d_rs_used,
    input  logic              w_d_rt_used,
    input  logic              w_d_rt_store,
    input  logic [ADDR_W-1:0] w_d_rs_addr,
    input  logic [ADDR_W-1:0] w_d_rt_addr,
    input  logic              w_d_wr_en,
    input  logic [ADDR_W-1:0] w_d_wr_addr,
    input  logic              w_d_is_load,
    input  logic              w_d_is_store,
    input  logic              w_flush,
    output logic              w_stall,
    output logic              w_freeze,
    output logic [1:0]        w_fwd_rs_sel,
    output logic [1:0]        w_fwd_rt_sel,
    output logic              w_wm_rt_bypass,
    output logic [CNT_W-1:0]  w_lost_cycles
);

    localparam logic [2:0] LAT_C = 3'(LOAD_LAT);

    typedef enum logic {
        MW_RUN  = 1'b0,
        MW_WAIT = 1'b1
    } mw_state_t;

    // E record
    logic              e_valid;
    logic              e_wr_en;
    logic [ADDR_W-1:0] e_wr_addr;
    logic              e_is_load;
    logic              e_is_store;
    logic              e_rs_used;
    logic              e_rt_used;
    logic              e_rt_store;
    logic [ADDR_W-1:0] e_rs_addr;
    logic [ADDR_W-1:0] e_rt_addr;

    // M record; rt address rides along for the store-data bypass
    logic              m_valid;
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_wr_addr;
    logic              m_is_load;
    logic              m_is_store;
    logic [ADDR_W-1:0] m_rt_addr;

    // W record; only the write-back destination matters here
    logic              wb_valid;
    logic              wb_wr_en;
    logic [ADDR_W-1:0] wb_wr_addr;

    mw_state_t         mw_state;
    mw_state_t         mw_next;
    logic [2:0]        ld_cnt;
    logic [2:0]        ld_cnt_next;

    logic              e_load_dst;
    logic              rs_dep;
    logic              rt_dep;
    logic              bubble;

    // A stage writes register r when it is live, enabled and r is not r0.
    function automatic logic writes_reg(input logic              v,
                                        input logic              we,
                                        input logic [ADDR_W-1:0] wa,
                                        input logic [ADDR_W-1:0] r);
        return v & we & (wa == r) & (r != '0);
    endfunction

    // Load-use detection against the load currently in E.
    always_comb begin
        e_load_dst = e_valid & e_is_load & e_wr_en & (e_wr_addr != '0);
        rs_dep     = w_d_rs_used & (w_d_rs_addr == e_wr_addr);
        rt_dep     = w_d_rt_used & ~w_d_rt_store & (w_d_rt_addr == e_wr_addr);
        w_stall    = w_d_valid & ~w_freeze & e_load_dst & (rs_dep | rt_dep);
        bubble     = w_stall | w_flush;
    end

    // Operand forwarding for the instruction in E; M wins over W, but a load
    // in M has no result yet and cannot forward.
    always_comb begin
        w_fwd_rs_sel = 2'b00;
        w_fwd_rt_sel = 2'b00;
        if (e_valid && e_rs_used) begin
            if (writes_reg(m_valid, m_wr_en, m_wr_addr, e_rs_addr) && !m_is_load) begin
                w_fwd_rs_sel = 2'b01;
            end else if (writes_reg(wb_valid, wb_wr_en, wb_wr_addr, e_rs_addr)) begin
                w_fwd_rs_sel = 2'b10;
            end
        end
        if (e_valid && e_rt_used && !e_rt_store) begin
            if (writes_reg(m_valid, m_wr_en, m_wr_addr, e_rt_addr) && !m_is_load) begin
                w_fwd_rt_sel = 2'b01;
            end else if (writes_reg(wb_valid, wb_wr_en, wb_wr_addr, e_rt_addr)) begin
                w_fwd_rt_sel = 2'b10;
            end
        end
    end

    // Store data in M picks up a result being written back by W, including loads.
    always_comb begin
        w_wm_rt_bypass = m_valid & m_is_store
                         & writes_reg(wb_valid, wb_wr_en, wb_wr_addr, m_rt_addr);
    end

    // Memory-wait next state: a load entering M starts the wait, which ends
    // once LOAD_LAT cycles have been spent frozen.
    always_comb begin
        mw_next     = mw_state;
        ld_cnt_next = 3'd0;
        w_freeze    = 1'b0;
        case (mw_state)
            MW_RUN: begin
                if (e_valid && e_is_load && (LAT_C != 3'd0)) begin
                    mw_next = MW_WAIT;
                end
            end
            MW_WAIT: begin
                w_freeze    = 1'b1;
                ld_cnt_next = ld_cnt + 3'd1;
                if (ld_cnt_next == LAT_C) begin
                    mw_next = MW_RUN;
                end
            end
            default: mw_next = MW_RUN;
        endcase
    end

    // Memory-wait state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mw_state <= MW_RUN;
            ld_cnt   <= 3'd0;
        end else begin
            mw_state <= mw_next;
            ld_cnt   <= ld_cnt_next;
        end
    end

    // Shadow pipeline records: shift on every unfrozen edge, bubble E on stall or flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            e_valid    <= 1'b0;
            e_wr_en    <= 1'b0;
            e_wr_addr  <= '0;
            e_is_load  <= 1'b0;
            e_is_store <= 1'b0;
            e_rs_used  <= 1'b0;
            e_rt_used  <= 1'b0;
            e_rt_store <= 1'b0;
            e_rs_addr  <= '0;
            e_rt_addr  <= '0;
            m_valid    <= 1'b0;
            m_wr_en    <= 1'b0;
            m_wr_addr  <= '0;
            m_is_load  <= 1'b0;
            m_is_store <= 1'b0;
            m_rt_addr  <= '0;
            wb_valid   <= 1'b0;
            wb_wr_en   <= 1'b0;
            wb_wr_addr <= '0;
        end else if (!w_freeze) begin
            wb_valid   <= m_valid;
            wb_wr_en   <= m_wr_en;
            wb_wr_addr <= m_wr_addr;
            m_valid    <= e_valid;
            m_wr_en    <= e_wr_en;
            m_wr_addr  <= e_wr_addr;
            m_is_load  <= e_is_load;
            m_is_store <= e_is_store;
            m_rt_addr  <= e_rt_addr;
            if (bubble) begin
                e_valid    <= 1'b0;
                e_wr_en    <= 1'b0;
                e_wr_addr  <= '0;
                e_is_load  <= 1'b0;
                e_is_store <= 1'b0;
                e_rs_used  <= 1'b0;
                e_rt_used  <= 1'b0;
                e_rt_store <= 1'b0;
                e_rs_addr  <= '0;
                e_rt_addr  <= '0;
            end else begin
                e_valid    <= w_d_valid;
                e_wr_en    <= w_d_wr_en;
                e_wr_addr  <= w_d_wr_addr;
                e_is_load  <= w_d_is_load;
                e_is_store <= w_d_is_store;
                e_rs_used  <= w_d_rs_used;
                e_rt_used  <= w_d_rt_used;
                e_rt_store <= w_d_rt_store;
                e_rs_addr  <= w_d_rs_addr;
                e_rt_addr  <= w_d_rt_addr;
            end
        end
    end

    // Saturating count of cycles lost to stall or freeze.
    always_ff @(posedge clock) begin
        if (!reset) begin
            w_lost_cycles <= '0;
        end else if ((w_stall || w_freeze) && (w_lost_cycles != '1)) begin
            w_lost_cycles <= w_lost_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Bench for hazard_unit_param: two instances (ideal memory and a 3-cycle
// memory) share decode stimulus and are compared every cycle against an
// instruction-level pipeline model.
module tb_hazard_unit_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       d_valid, d_rs_used, d_rt_used, d_rt_store;
    logic [4:0] d_rs_addr, d_rt_addr, d_wr_addr;
    logic       d_wr_en, d_is_load, d_is_store, flush;

    logic       stall0, freeze0, byp0;
    logic [1:0] rs0, rt0;
    logic [3:0] lost0;
    logic       stall3, freeze3, byp3;
    logic [1:0] rs3, rt3;
    logic [5:0] lost3;

    always #5 clock = ~clock;

    hazard_unit_param #(.ADDR_W(5), .LOAD_LAT(0), .CNT_W(4)) u_lat0 (
        .clock(clock), .reset(reset),
        .w_d_valid(d_valid), .w_d_rs_used(d_rs_used), .w_d_rt_used(d_rt_used),
        .w_d_rt_store(d_rt_store), .w_d_rs_addr(d_rs_addr), .w_d_rt_addr(d_rt_addr),
        .w_d_wr_en(d_wr_en), .w_d_wr_addr(d_wr_addr), .w_d_is_load(d_is_load),
        .w_d_is_store(d_is_store), .w_flush(flush),
        .w_stall(stall0), .w_freeze(freeze0), .w_fwd_rs_sel(rs0), .w_fwd_rt_sel(rt0),
        .w_wm_rt_bypass(byp0), .w_lost_cycles(lost0)
    );

    hazard_unit_param #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(6)) u_lat3 (
        .clock(clock), .reset(reset),
        .w_d_valid(d_valid), .w_d_rs_used(d_rs_used), .w_d_rt_used(d_rt_used),
        .w_d_rt_store(d_rt_store), .w_d_rs_addr(d_rs_addr), .w_d_rt_addr(d_rt_addr),
        .w_d_wr_en(d_wr_en), .w_d_wr_addr(d_wr_addr), .w_d_is_load(d_is_load),
        .w_d_is_store(d_is_store), .w_flush(flush),
        .w_stall(stall3), .w_freeze(freeze3), .w_fwd_rs_sel(rs3), .w_fwd_rt_sel(rt3),
        .w_wm_rt_bypass(byp3), .w_lost_cycles(lost3)
    );

    typedef struct {
        bit valid, wr_en, is_load, is_store, rs_used, rt_used, rt_store;
        int wr_addr, rs_addr, rt_addr;
    } instr_t;

    // Model state per instance: instructions occupying E, M, W.
    instr_t pe[2], pm[2], pw[2];
    int     wait_left[2];
    int     lost_m[2];
    int     n_assert = 0;
    int     n_fail   = 0;

    function automatic int lat_of(int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int max_of(int i);
        return (i == 0) ? 15 : 63;
    endfunction

    function automatic instr_t empty_instr();
        instr_t r;
        r.valid = 0; r.wr_en = 0; r.is_load = 0; r.is_store = 0;
        r.rs_used = 0; r.rt_used = 0; r.rt_store = 0;
        r.wr_addr = 0; r.rs_addr = 0; r.rt_addr = 0;
        return r;
    endfunction

    function automatic instr_t decode_instr();
        instr_t r;
        r.valid = d_valid; r.wr_en = d_wr_en; r.is_load = d_is_load;
        r.is_store = d_is_store; r.rs_used = d_rs_used; r.rt_used = d_rt_used;
        r.rt_store = d_rt_store; r.wr_addr = int'(d_wr_addr);
        r.rs_addr = int'(d_rs_addr); r.rt_addr = int'(d_rt_addr);
        return r;
    endfunction

    function automatic bit writes(instr_t s, int r);
        return s.valid && s.wr_en && (s.wr_addr == r) && (r != 0);
    endfunction

    function automatic bit exp_freeze(int i);
        return pm[i].valid && pm[i].is_load && (wait_left[i] > 0);
    endfunction

    function automatic bit exp_stall(int i);
        instr_t d = decode_instr();
        instr_t e = pe[i];
        bit dep;
        if (!d.valid || exp_freeze(i)) return 0;
        if (!(e.valid && e.is_load && e.wr_en && e.wr_addr != 0)) return 0;
        dep = (d.rs_used && d.rs_addr == e.wr_addr) ||
              (d.rt_used && !d.rt_store && d.rt_addr == e.wr_addr);
        return dep;
    endfunction

    function automatic int exp_sel(int i, bit used, int a);
        if (!pe[i].valid || !used || a == 0) return 0;
        if (writes(pm[i], a) && !pm[i].is_load) return 1;
        if (writes(pw[i], a)) return 2;
        return 0;
    endfunction

    function automatic bit exp_byp(int i);
        return pm[i].valid && pm[i].is_store && writes(pw[i], pm[i].rt_addr);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] o_st, o_fr, o_rs, o_rt, o_by, o_lo;
            string p;
            p = (i == 0) ? "lat0" : "lat3";
            if (i == 0) begin
                o_st = 32'(stall0); o_fr = 32'(freeze0); o_rs = 32'(rs0);
                o_rt = 32'(rt0); o_by = 32'(byp0); o_lo = 32'(lost0);
            end else begin
                o_st = 32'(stall3); o_fr = 32'(freeze3); o_rs = 32'(rs3);
                o_rt = 32'(rt3); o_by = 32'(byp3); o_lo = 32'(lost3);
            end
            chk({p, "_stall"},  o_st, 32'(exp_stall(i)));
            chk({p, "_freeze"}, o_fr, 32'(exp_freeze(i)));
            chk({p, "_rs_sel"}, o_rs, 32'(exp_sel(i, pe[i].rs_used, pe[i].rs_addr)));
            chk({p, "_rt_sel"}, o_rt, 32'(exp_sel(i, pe[i].rt_used && !pe[i].rt_store, pe[i].rt_addr)));
            chk({p, "_bypass"}, o_by, 32'(exp_byp(i)));
            chk({p, "_lost"},   o_lo, 32'(lost_m[i]));
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit st, fr;
            st = exp_stall(i);
            fr = exp_freeze(i);
            if (!reset) begin
                pe[i] = empty_instr(); pm[i] = empty_instr(); pw[i] = empty_instr();
                wait_left[i] = 0; lost_m[i] = 0;
            end else begin
                if ((st || fr) && lost_m[i] < max_of(i)) lost_m[i]++;
                if (fr) begin
                    wait_left[i]--;
                end else begin
                    pw[i] = pm[i];
                    pm[i] = pe[i];
                    wait_left[i] = lat_of(i);
                    pe[i] = (st || flush) ? empty_instr() : decode_instr();
                end
            end
        end
    endtask

    task automatic cycle();
        check_all();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input bit v, input bit ld, input bit st, input bit we, input int wa,
                       input bit ru, input int ra, input bit tu, input int ta, input bit fl);
        d_valid = v; d_is_load = ld; d_is_store = st; d_rt_store = st;
        d_wr_en = we; d_wr_addr = 5'(wa); d_rs_used = ru; d_rs_addr = 5'(ra);
        d_rt_used = tu; d_rt_addr = 5'(ta); flush = fl;
        #1;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        nop(); cycle();
        nop(); cycle();
        reset = 1'b1;
    endtask

    task automatic rand_instr();
        int k;
        if ($urandom % 10 < 8) begin
            k = int'($urandom % 10);
            if (k < 3)
                drv(1, 1, 0, 1, int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 3)), 0, 0,
                    ($urandom % 10) == 0);
            else if (k < 5)
                drv(1, 0, 1, 0, 0, 1, int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 3)),
                    ($urandom % 10) == 0);
            else
                drv(1, 0, 0, ($urandom % 4) != 0, int'($urandom_range(0, 3)),
                    ($urandom % 5) != 0, int'($urandom_range(0, 3)),
                    ($urandom % 2) != 0, int'($urandom_range(0, 3)), ($urandom % 10) == 0);
        end else begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, ($urandom % 10) == 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pe[i] = empty_instr(); pm[i] = empty_instr(); pw[i] = empty_instr();
            wait_left[i] = 0; lost_m[i] = 0;
        end
        reset = 1'b0;
        nop();
        @(posedge clock); #1;
        do_reset();

        // Reset state with a valid reader in decode
        drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 0);
        chk("rst_stall0", 32'(stall0), 0);
        chk("rst_freeze3", 32'(freeze3), 0);
        chk("rst_sel0", 32'({rs0, rt0}), 0);
        chk("rst_bypass0", 32'(byp0), 0);
        chk("rst_lost0", 32'(lost0), 0);
        chk("rst_lost3", 32'(lost3), 0);
        cycle();

        // Load-use on ideal memory: one bubble then W forwarding
        drv(1, 1, 0, 1, 8, 1, 1, 0, 0, 0); cycle();
        drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 0);
        chk("lu_stall_on", 32'(stall0), 1); cycle();
        drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 0);
        chk("lu_stall_off", 32'(stall0), 0); cycle();
        nop();
        chk("lu_rs_w", 32'(rs0), 2);
        chk("lu_rt_w", 32'(rt0), 2);
        chk("lu_lost", 32'(lost0), 1); cycle();

        // Load-use with 3-cycle memory
        do_reset();
        drv(1, 1, 0, 1, 8, 1, 1, 0, 0, 0); cycle();
        drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 0);
        chk("mw_stall", 32'(stall3), 1); cycle();
        for (int c = 0; c < 3; c++) begin
            drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 0);
            chk("mw_freeze_on", 32'(freeze3), 1); cycle();
        end
        drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 0);
        chk("mw_freeze_off", 32'(freeze3), 0);
        chk("mw_no_stall", 32'(stall3), 0); cycle();
        nop();
        chk("mw_rs_w", 32'(rs3), 2);
        chk("mw_lost", 32'(lost3), 4); cycle();

        // ALU chain: M then W forwarding, no stall
        do_reset();
        drv(1, 0, 0, 1, 3, 1, 1, 1, 2, 0); cycle();
        drv(1, 0, 0, 1, 4, 1, 3, 1, 5, 0); cycle();
        drv(1, 0, 0, 1, 6, 1, 3, 1, 7, 0);
        chk("alu_rs_m0", 32'(rs0), 1);
        chk("alu_rs_m3", 32'(rs3), 1);
        chk("alu_rt_m0", 32'(rt0), 0); cycle();
        nop();
        chk("alu_rs_w0", 32'(rs0), 2);
        chk("alu_rs_w3", 32'(rs3), 2);
        chk("alu_stall0", 32'(stall0), 0); cycle();

        // Load then store of the loaded value: bypass at M
        do_reset();
        drv(1, 1, 0, 1, 8, 1, 1, 0, 0, 0); cycle();
        drv(1, 0, 1, 0, 0, 1, 2, 1, 8, 0);
        chk("st_no_stall", 32'(stall0), 0); cycle();
        nop(); cycle();
        nop();
        chk("st_bypass", 32'(byp0), 1); cycle();

        // r0 never forwards or stalls
        do_reset();
        drv(1, 0, 0, 1, 0, 1, 1, 1, 1, 0); cycle();
        drv(1, 0, 0, 1, 5, 1, 0, 1, 0, 0); cycle();
        drv(1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        chk("r0_rs", 32'(rs0), 0);
        chk("r0_rt", 32'(rt0), 0); cycle();
        drv(1, 0, 0, 1, 6, 1, 0, 1, 0, 0);
        chk("r0_stall0", 32'(stall0), 0);
        chk("r0_stall3", 32'(stall3), 0); cycle();
        nop(); cycle();

        // Flush coinciding with load-use: single bubble
        drv(1, 1, 0, 1, 8, 1, 1, 0, 0, 0); cycle();
        drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 1);
        chk("fl_stall", 32'(stall0), 1); cycle();
        nop();
        chk("fl_bubble_stall", 32'(stall0), 0);
        chk("fl_bubble_rs", 32'(rs0), 0); cycle();

        // Reset in the middle of a freeze
        do_reset();
        drv(1, 1, 0, 1, 8, 1, 1, 0, 0, 0); cycle();
        nop(); cycle();
        reset = 1'b0;
        nop();
        chk("rf_freeze", 32'(freeze3), 1); cycle();
        reset = 1'b1;
        drv(1, 0, 0, 1, 9, 1, 8, 1, 8, 0);
        chk("rf_freeze_clr", 32'(freeze3), 0);
        chk("rf_stall_clr", 32'(stall3), 0);
        chk("rf_sel_clr", 32'({rs3, rt3}), 0);
        chk("rf_bypass_clr", 32'(byp3), 0);
        chk("rf_lost_clr", 32'(lost3), 0); cycle();

        // Random traffic with occasional resets
        for (int n = 0; n < 2500; n++) begin
            reset = ($urandom % 80) != 0;
            rand_instr();
            cycle();
        end

        // Random traffic without reset until both counters saturate
        reset = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            rand_instr();
            cycle();
        end
        nop();
        chk("sat_lost0", 32'(lost0), 15);
        chk("sat_lost3", 32'(lost3), 63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
